// File: rtl/llc_trace_issuer.sv
// llc_trace_issuer: buffers trace records and issues them to the LLC model as single-cycle strobes
// separated by NOP gaps, dropping illegal codes and keeping issue/drop statistics.
module llc_trace_issuer #(
   parameter int CMDSIZE    = 4,
   parameter int ADDR_BITS  = 32,
   parameter int DEPTH      = 8,
   parameter int GAP_CYCLES = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   trc_valid,
   output logic                   trc_ready,
   input  logic [CMDSIZE-1:0]     trc_cmd,
   input  logic [ADDR_BITS-1:0]   trc_addr,
   input  logic                   trc_last,
   output logic [CMDSIZE-1:0]     command,
   output logic [ADDR_BITS-1:0]   address,
   output logic                   cmd_strobe,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic [31:0]            issued_cnt,
   output logic [31:0]            dropped_cnt,
   output logic                   done
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam logic [CMDSIZE-1:0] NOP = CMDSIZE'(7);
   typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;
   state_t state, state_n;
   logic [CMDSIZE-1:0]   mem_cmd  [DEPTH];
   logic [ADDR_BITS-1:0] mem_addr [DEPTH];
   logic                 mem_last [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [GW-1:0] gap_cnt;
   logic cur_last, drop_last, legal, accept, push, pop, empty, gap_end;
   assign trc_ready = fifo_count < CW'(DEPTH);
   always_comb begin
      legal   = trc_cmd <= CMDSIZE'(6) || trc_cmd == CMDSIZE'(8) || trc_cmd == CMDSIZE'(9);
      accept  = trc_valid && trc_ready;
      push    = accept && legal;
      empty   = fifo_count == '0;
      gap_end = state == GAP && gap_cnt == GW'(1);
      pop     = !empty && (state == IDLE || gap_end);
      state_n = pop ? ISSUE : state == ISSUE ? GAP : (state == GAP && !gap_end) ? GAP : IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else state <= state_n;
   end
   always_ff @(posedge clk) begin
      if (push) begin
         mem_cmd[wr_ptr]  <= trc_cmd;
         mem_addr[wr_ptr] <= trc_addr;
         mem_last[wr_ptr] <= trc_last;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fifo_count  <= '0;
         command     <= NOP;
         address     <= '0;
         cmd_strobe  <= 1'b0;
         issued_cnt  <= '0;
         dropped_cnt <= '0;
         done        <= 1'b0;
         cur_last    <= 1'b0;
         drop_last   <= 1'b0;
         gap_cnt     <= '0;
      end else begin
         wr_ptr     <= wr_ptr + AW'(push);
         rd_ptr     <= rd_ptr + AW'(pop);
         fifo_count <= fifo_count + CW'(push) - CW'(pop);
         cmd_strobe <= pop;
         if (accept && !legal) dropped_cnt <= dropped_cnt + 32'd1;
         // An illegal last record never reaches the cache, so it completes once the issuer drains.
         if (accept && !legal && trc_last) drop_last <= 1'b1;
         if (pop) begin
            command    <= mem_cmd[rd_ptr];
            address    <= mem_addr[rd_ptr];
            cur_last   <= mem_last[rd_ptr];
            issued_cnt <= issued_cnt + 32'd1;
         end else if (state == ISSUE) begin
            command <= NOP;
            gap_cnt <= GW'(GAP_CYCLES);
         end
         if (state == GAP) gap_cnt <= gap_cnt - GW'(1);
         if ((gap_end && cur_last) || (drop_last && empty && state == IDLE)) done <= 1'b1;
      end
   end
endmodule

// File: tb/tb_llc_trace_issuer.sv
// tb_llc_trace_issuer: directed vectors and hand-built sequences for the trace issuer,
// with a GAP_CYCLES=1 instance and a GAP_CYCLES=3 instance sharing the stimulus.
module tb_llc_trace_issuer;
   logic clk, rst, valid, last;
   logic [3:0] cmd;
   logic [31:0] addr;
   logic ready, strobe, done;
   logic [3:0] command, count;
   logic [31:0] address, issued, dropped;
   logic r3, s3, dn3;
   logic [3:0] c3, n3;
   logic [31:0] a3, i3, d3;
   int checks = 0, errors = 0;

   llc_trace_issuer #(.GAP_CYCLES(1)) dut (
      .clk(clk), .rst(rst), .trc_valid(valid), .trc_ready(ready), .trc_cmd(cmd), .trc_addr(addr),
      .trc_last(last), .command(command), .address(address), .cmd_strobe(strobe),
      .fifo_count(count), .issued_cnt(issued), .dropped_cnt(dropped), .done(done));
   llc_trace_issuer #(.GAP_CYCLES(3)) dut3 (
      .clk(clk), .rst(rst), .trc_valid(valid), .trc_ready(r3), .trc_cmd(cmd), .trc_addr(addr),
      .trc_last(last), .command(c3), .address(a3), .cmd_strobe(s3),
      .fifo_count(n3), .issued_cnt(i3), .dropped_cnt(d3), .done(dn3));

   always #5 clk = ~clk;

   typedef struct {
      logic v; logic [3:0] c; logic [31:0] a; logic l;
      logic s; logic [3:0] ec; logic [31:0] ea; logic [3:0] n; logic [31:0] iss; logic [31:0] drp; logic d;
   } vec_t;
   vec_t tbl[11];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      valid = 1'b0;
      last = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int i, nstr, last_cyc, bad_rdy, nop_seen, nop_between, max_n, fin_cyc, done_cyc;
      logic pushed;
      clk = 1'b0; rst = 1'b1; valid = 1'b0; cmd = '0; addr = '0; last = 1'b0;
      tick();
      do_reset();
      check("rst_command", command, 7);
      check("rst_address", address, 0);
      check("rst_strobe", strobe, 0);
      check("rst_count", count, 0);
      check("rst_issued", issued, 0);
      check("rst_dropped", dropped, 0);
      check("rst_done", done, 0);
      check("rst_ready", ready, 1);

      // single record with last, then two illegal codes and one legal
      tbl[0]  = '{1'b1, 4'd0,  32'h1000, 1'b1, 1'b0, 4'd7, 32'h0,    4'd1, 32'd0, 32'd0, 1'b0};
      tbl[1]  = '{1'b0, 4'd0,  32'h0,    1'b0, 1'b1, 4'd0, 32'h1000, 4'd0, 32'd1, 32'd0, 1'b0};
      tbl[2]  = '{1'b0, 4'd0,  32'h0,    1'b0, 1'b0, 4'd7, 32'h1000, 4'd0, 32'd1, 32'd0, 1'b0};
      tbl[3]  = '{1'b0, 4'd0,  32'h0,    1'b0, 1'b0, 4'd7, 32'h1000, 4'd0, 32'd1, 32'd0, 1'b1};
      tbl[4]  = '{1'b1, 4'd7,  32'h10,   1'b0, 1'b0, 4'd7, 32'h1000, 4'd0, 32'd1, 32'd1, 1'b1};
      tbl[5]  = '{1'b1, 4'd12, 32'h20,   1'b0, 1'b0, 4'd7, 32'h1000, 4'd0, 32'd1, 32'd2, 1'b1};
      tbl[6]  = '{1'b1, 4'd4,  32'h40,   1'b0, 1'b0, 4'd7, 32'h1000, 4'd1, 32'd1, 32'd2, 1'b1};
      tbl[7]  = '{1'b0, 4'd0,  32'h0,    1'b0, 1'b1, 4'd4, 32'h40,   4'd0, 32'd2, 32'd2, 1'b1};
      tbl[8]  = '{1'b0, 4'd0,  32'h0,    1'b0, 1'b0, 4'd7, 32'h40,   4'd0, 32'd2, 32'd2, 1'b1};
      tbl[9]  = '{1'b0, 4'd0,  32'h0,    1'b0, 1'b0, 4'd7, 32'h40,   4'd0, 32'd2, 32'd2, 1'b1};
      tbl[10] = '{1'b0, 4'd0,  32'h0,    1'b0, 1'b0, 4'd7, 32'h40,   4'd0, 32'd2, 32'd2, 1'b1};
      for (int k = 0; k < 11; k++) begin
         valid = tbl[k].v; cmd = tbl[k].c; addr = tbl[k].a; last = tbl[k].l;
         tick();
         check($sformatf("v%0d_strobe", k), strobe, tbl[k].s);
         check($sformatf("v%0d_command", k), command, tbl[k].ec);
         check($sformatf("v%0d_address", k), address, tbl[k].ea);
         check($sformatf("v%0d_count", k), count, tbl[k].n);
         check($sformatf("v%0d_issued", k), issued, tbl[k].iss);
         check($sformatf("v%0d_dropped", k), dropped, tbl[k].drp);
         check($sformatf("v%0d_done", k), done, tbl[k].d);
      end

      // two identical records must appear as two strobes with a NOP between
      nstr = 0; nop_seen = 0; nop_between = 0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         valid = cyc < 2; cmd = 4'd1; addr = 32'hABC0; last = 1'b0;
         tick();
         if (strobe) begin
            check("dup_command", command, 1);
            check("dup_address", address, 32'hABC0);
            if (nstr == 1 && nop_seen) nop_between = 1;
            nstr++;
            nop_seen = 0;
         end else if (command == 4'd7) nop_seen = 1;
      end
      check("dup_strobes", nstr, 2);
      check("dup_nop_between", nop_between, 1);

      // ten legal records, valid held high
      do_reset();
      i = 0; nstr = 0; last_cyc = 0; bad_rdy = 0;
      for (int cyc = 0; cyc < 60; cyc++) begin
         valid = i < 10; cmd = 4'(i % 7); addr = 32'h100 + 32'(i * 4); last = 1'b0;
         pushed = valid && ready;
         tick();
         if (pushed) i++;
         if (ready !== (count < 4'd8)) bad_rdy++;
         if (strobe) begin
            check($sformatf("fill_cmd%0d", nstr), command, 4'(nstr % 7));
            check($sformatf("fill_addr%0d", nstr), address, 32'h100 + 32'(nstr * 4));
            if (nstr > 0) check($sformatf("fill_gap%0d", nstr), cyc - last_cyc, 2);
            last_cyc = cyc;
            nstr++;
         end
      end
      check("fill_strobes", nstr, 10);
      check("fill_issued", issued, 10);
      check("fill_ready_rule", bad_rdy, 0);

      // reset while five records are buffered and one is in its gap
      do_reset();
      for (int k = 0; k < 9; k++) begin
         valid = 1'b1; cmd = 4'd2; addr = 32'(k); last = 1'b0;
         tick();
      end
      valid = 1'b0;
      check("mid_count", count, 5);
      check("mid_command", command, 7);
      check("mid_issued", issued, 4);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst2_count", count, 0);
      check("rst2_command", command, 7);
      check("rst2_issued", issued, 0);
      check("rst2_dropped", dropped, 0);
      nstr = 0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         tick();
         if (strobe) nstr++;
      end
      check("rst2_no_strobes", nstr, 0);

      // GAP_CYCLES=3 instance, twelve records pushed whenever accepted
      do_reset();
      i = 0; nstr = 0; last_cyc = 0; bad_rdy = 0; max_n = 0; fin_cyc = -1; done_cyc = -1;
      for (int cyc = 0; cyc < 100; cyc++) begin
         valid = i < 12; cmd = 4'd5; addr = 32'(i); last = i == 11;
         pushed = valid && r3;
         tick();
         if (pushed) i++;
         if (r3 !== (n3 < 4'd8)) bad_rdy++;
         if (int'(n3) > max_n) max_n = int'(n3);
         if (s3) begin
            check($sformatf("g3_addr%0d", nstr), a3, nstr);
            if (nstr > 0) check($sformatf("g3_period%0d", nstr), cyc - last_cyc, 4);
            last_cyc = cyc;
            nstr++;
            if (nstr == 12) fin_cyc = cyc;
         end
         if (dn3 && done_cyc < 0) done_cyc = cyc;
      end
      valid = 1'b0;
      check("g3_strobes", nstr, 12);
      check("g3_issued", i3, 12);
      check("g3_max_count", max_n, 8);
      check("g3_ready_rule", bad_rdy, 0);
      check("g3_done_delay", done_cyc - fin_cyc, 4);
      check("g3_done_seen", fin_cyc >= 0 && done_cyc >= 0, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
